timer_mbus: RTL and testbench

Memory-mapped timer/counter peripheral on the CPU memory bus, downstream of the CPU's `mbus_aout`/`mbus_dout`/`mbus_wen`/`mbus_din` lines. It provides:

- a programmable prescaler;
- an auto-reload up-counter with overflow flag;
- one-shot mode;
- a level interrupt request.

An external address decoder drives `cs`. Read data is combinational, so the CPU latches it during its memory phase without wait states.

---
 rtl/timer_mbus.sv | 116 +++++++++++
 tb/tb_timer_mbus.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mbus.sv
// timer_mbus: memory-mapped timer with a prescaler, an auto-reload up-counter,
// one-shot mode and a level interrupt. Reads are combinational, so the CPU needs no wait states.
module timer_mbus #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    input  logic             wen,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    localparam logic [2:0] ADDR_CNT  = 3'd0;
    localparam logic [2:0] ADDR_AR   = 3'd1;
    localparam logic [2:0] ADDR_CTRL = 3'd2;
    localparam logic [2:0] ADDR_STAT = 3'd3;
    localparam logic [2:0] ADDR_PRE  = 3'd4;
    localparam logic [2:0] ADDR_PCNT = 3'd5;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] pcnt;
    logic             en;
    logic             ie;
    logic             oneshot;
    logic             ovf;

    logic wr;
    logic tick;
    logic wrap;
    logic en_rise;

    assign wr      = cs & wen;
    assign tick    = en & (pcnt == pre);
    assign wrap    = tick & (cnt == ar);
    assign en_rise = wr & (addr == ADDR_CTRL) & din[0] & ~en;

    // Prescaler: enabling EN from software restarts the divide so the first tick lands PRE+1 cycles later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt <= '0;
        end else if (en_rise) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= (pcnt == pre) ? '0 : pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (wr && addr == ADDR_CNT) begin
            cnt <= din;
        end else if (tick) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ar  <= '0;
            pre <= '0;
        end else if (wr) begin
            if (addr == ADDR_AR)  ar  <= din;
            if (addr == ADDR_PRE) pre <= din;
        end
    end

    // A software CTRL write wins over the one-shot auto-disable on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            oneshot <= 1'b0;
        end else if (wr && addr == ADDR_CTRL) begin
            en      <= din[0];
            ie      <= din[1];
            oneshot <= din[2];
        end else if (wrap && oneshot) begin
            en <= 1'b0;
        end
    end

    // A hardware overflow on the same edge as a w1c clear leaves OVF set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (wrap) begin
            ovf <= 1'b1;
        end else if (wr && addr == ADDR_STAT && din[0]) begin
            ovf <= 1'b0;
        end
    end

    always_comb begin
        dout = '0;
        if (cs) begin
            case (addr)
                ADDR_CNT:  dout = cnt;
                ADDR_AR:   dout = ar;
                ADDR_CTRL: dout = {{(WIDTH-3){1'b0}}, oneshot, ie, en};
                ADDR_STAT: dout = {{(WIDTH-1){1'b0}}, ovf};
                ADDR_PRE:  dout = pre;
                ADDR_PCNT: dout = pcnt;
                default:   dout = '0;
            endcase
        end
    end

    assign irq = ovf & ie;

endmodule

// File: tb/tb_timer_mbus.sv
// tb_timer_mbus: directed scenarios with literal expectations plus a random phase,
// every cycle compared against a register-level model of the timer.
module tb_timer_mbus;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [2:0]  addr;
    logic [31:0] din;
    logic        wen;
    logic [31:0] dout;
    logic        irq;

    int tests;
    int fails;
    bit checkOn;

    // Model state, kept as plain register values.
    logic [31:0] mCnt, mAr, mPre, mPcnt;
    bit          mEn, mIe, mOne, mOvf;
    logic [31:0] nCnt, nAr, nPre, nPcnt;
    bit          nEn, nIe, nOne, nOvf;
    bit          doTick, hitTerm;

    timer_mbus #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .addr  (addr),
        .din   (din),
        .wen   (wen),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        case (a)
            3'd0:    return mCnt;
            3'd1:    return mAr;
            3'd2:    return {29'b0, mOne, mIe, mEn};
            3'd3:    return {31'b0, mOvf};
            3'd4:    return mPre;
            3'd5:    return mPcnt;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            mCnt = 0; mAr = 0; mPre = 0; mPcnt = 0;
            mEn = 0; mIe = 0; mOne = 0; mOvf = 0;
        end else begin
            doTick  = mEn && (mPcnt == mPre);
            hitTerm = doTick && (mCnt == mAr);
            nCnt  = doTick ? (hitTerm ? 32'h0 : mCnt + 32'h1) : mCnt;
            nPcnt = mEn ? ((mPcnt == mPre) ? 32'h0 : mPcnt + 32'h1) : mPcnt;
            nAr   = mAr;
            nPre  = mPre;
            nEn   = mEn && !(hitTerm && mOne);
            nIe   = mIe;
            nOne  = mOne;
            nOvf  = mOvf || hitTerm;
            if (cs && wen) begin
                case (addr)
                    3'd0: nCnt = din;
                    3'd1: nAr = din;
                    3'd2: begin
                        nEn = din[0]; nIe = din[1]; nOne = din[2];
                        if (din[0] && !mEn) nPcnt = 0;
                    end
                    3'd3: if (din[0] && !hitTerm) nOvf = 0;
                    3'd4: nPre = din;
                    default: ;
                endcase
            end
            mCnt = nCnt; mAr = nAr; mPre = nPre; mPcnt = nPcnt;
            mEn = nEn; mIe = nIe; mOne = nOne; mOvf = nOvf;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("model_dout", dout, cs ? modelRead(addr) : 32'h0);
            checkOutput("model_irq", {31'b0, irq}, {31'b0, mOvf & mIe});
        end
    end

    // Inputs change 1 time unit after the rising edge and are held for one cycle.
    task automatic applyStimulus(input bit c, input bit w, input logic [2:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        cs = c; wen = w; addr = a; din = d;
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
    endtask

    task automatic readCheck(input logic [2:0] a, input logic [31:0] exp, input string name);
        applyStimulus(1'b1, 1'b0, a, 32'h0);
        #2;
        checkOutput(name, dout, exp);
    endtask

    task automatic stopAndClear();
        writeReg(3'd2, 32'h0);
        writeReg(3'd3, 32'h1);
        writeReg(3'd0, 32'h0);
    endtask

    initial begin
        tests = 0; fails = 0; checkOn = 0;
        reset = 1'b0; cs = 0; wen = 0; addr = 0; din = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOn = 1;

        // Reset and defaults
        writeReg(3'd0, 32'h1234);
        writeReg(3'd1, 32'h5);
        writeReg(3'd4, 32'h7);
        writeReg(3'd2, 32'h3);
        applyStimulus(1'b1, 1'b1, 3'd0, 32'hABCD);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 3'd1, 32'h99);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            readCheck(3'(i), 32'h0, "reset_read");
            checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        end

        // Basic count
        writeReg(3'd4, 32'h0);
        writeReg(3'd1, 32'h3);
        writeReg(3'd2, 32'h3);
        readCheck(3'd0, 32'h0, "basic_cnt0");
        readCheck(3'd0, 32'h1, "basic_cnt1");
        readCheck(3'd0, 32'h2, "basic_cnt2");
        readCheck(3'd0, 32'h3, "basic_cnt3");
        readCheck(3'd3, 32'h1, "basic_ovf");
        checkOutput("basic_irq_high", {31'b0, irq}, 32'h1);
        writeReg(3'd3, 32'h1);
        readCheck(3'd0, 32'h2, "basic_cnt_after_clr");
        checkOutput("basic_irq_low", {31'b0, irq}, 32'h0);
        stopAndClear();

        // Prescaler
        writeReg(3'd4, 32'h2);
        writeReg(3'd1, 32'h1);
        writeReg(3'd2, 32'h1);
        readCheck(3'd5, 32'h0, "pre_pcnt0");
        readCheck(3'd5, 32'h1, "pre_pcnt1");
        readCheck(3'd5, 32'h2, "pre_pcnt2");
        readCheck(3'd0, 32'h1, "pre_cnt1");
        readCheck(3'd3, 32'h0, "pre_ovf_e4");
        readCheck(3'd3, 32'h0, "pre_ovf_e5");
        readCheck(3'd3, 32'h1, "pre_ovf_e6");
        stopAndClear();

        // One-shot
        writeReg(3'd4, 32'h0);
        writeReg(3'd1, 32'h2);
        writeReg(3'd2, 32'h5);
        readCheck(3'd0, 32'h0, "os_cnt0");
        readCheck(3'd0, 32'h1, "os_cnt1");
        readCheck(3'd0, 32'h2, "os_cnt2");
        readCheck(3'd2, 32'h4, "os_ctrl");
        for (int i = 0; i < 10; i++) readCheck(3'd0, 32'h0, "os_cnt_hold");
        stopAndClear();

        // Collision: CNT write on a tick edge
        writeReg(3'd1, 32'd100);
        writeReg(3'd2, 32'h1);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0);
        writeReg(3'd0, 32'h10);
        readCheck(3'd0, 32'h10, "col_cnt_write");
        stopAndClear();

        // Collision: w1c on the overflow edge
        writeReg(3'd1, 32'h0);
        writeReg(3'd2, 32'h1);
        writeReg(3'd3, 32'h1);
        readCheck(3'd3, 32'h1, "col_ovf_w1c");
        stopAndClear();

        // Collision: CTRL write on the one-shot terminal edge
        writeReg(3'd1, 32'h1);
        writeReg(3'd2, 32'h5);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0);
        writeReg(3'd2, 32'h5);
        readCheck(3'd2, 32'h5, "col_ctrl_os");
        stopAndClear();

        // Bus decode
        writeReg(3'd0, 32'h55);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'hDEAD);
        readCheck(3'd0, 32'h55, "dec_cs_low_write");
        writeReg(3'd5, 32'h77);
        readCheck(3'd5, 32'h0, "dec_pcnt_ro");
        writeReg(3'd6, 32'hFFFF);
        readCheck(3'd6, 32'h0, "dec_addr6");
        readCheck(3'd7, 32'h0, "dec_addr7");
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0);
        #2;
        checkOutput("dec_cs_low_dout", dout, 32'h0);

        // Random phase, checked every cycle against the model
        for (int i = 0; i < 2500; i++) begin
            logic [31:0] d;
            d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 5));
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), d);
            reset = ($urandom_range(0, 299) != 0);
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0);
        @(negedge clk);
        #1;
        checkOn = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
